// File: rtl/saturation_adj_pp_if.sv
// Video stream beat bundle used on both sides of the saturation adjust stage.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready are both 1; once tvalid is high, tdata/tuser/tlast hold until that transfer.
`timescale 1ns/1ps
interface saturation_adj_pp_if #(
  parameter int DATA_W = 96
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, output tvalid, input tready, output tuser, output tlast);
  modport slave  (input tdata, input tvalid, output tready, input tuser, input tlast);
endinterface

// File: rtl/saturation_adj_pp.sv
// Saturation adjust, out = X + s*(X - Y) per component with BT.601 luma Y.
// Four-stage pipeline; the adjust and bypass settings are latched at start-of-frame and ride along with each beat.
`timescale 1ns/1ps
module saturation_adj_pp #(
  parameter int                PIX_NUM     = 4,
  parameter int                COMP_W      = 8,
  parameter logic signed [8:0] ADJ_DEFAULT = 9'sd0
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  saturation_adj_pp_if.slave  I_axis,
  saturation_adj_pp_if.master O_axis,
  input  logic signed [8:0]   I_adj_val,
  input  logic                I_bypass,
  output logic [15:0]         O_frame_cnt
);
  localparam int PIX_W = 3 * COMP_W;
  localparam int PW    = COMP_W + 10;
  localparam int SW    = COMP_W + 11;
  localparam int EW    = SW + 1;
  localparam logic signed [EW-1:0] C_MAXV = EW'((1 << COMP_W) - 1);
  localparam logic [COMP_W-1:0]    C_MAX  = '1;

  logic                            w_en;
  logic                            w_acc;
  logic                            w_sof;
  logic signed [8:0]               w_adj;
  logic                            w_bypass;
  logic signed [9:0]               w_coef;

  logic signed [8:0]               r_adj;
  logic                            r_bypass;
  logic [15:0]                     r_frame_cnt;

  logic [3:0]                      r_vld;
  logic [3:0]                      r_user;
  logic [3:0]                      r_last;
  logic [2:0]                      r_byp;
  logic signed [8:0]               r_s1_adj;
  logic signed [8:0]               r_s2_adj;

  logic [PIX_NUM-1:0][PIX_W-1:0]   r_s1_pix;
  logic [PIX_NUM-1:0][PIX_W-1:0]   r_s2_pix;
  logic [PIX_NUM-1:0][PIX_W-1:0]   r_s3_pix;
  logic [PIX_NUM-1:0][2:0][PW-1:0] w_s1_prod;
  logic [PIX_NUM-1:0][2:0][PW-1:0] r_s1_prod;
  logic [PIX_NUM-1:0][COMP_W-1:0]  w_s2_y;
  logic [PIX_NUM-1:0][COMP_W-1:0]  r_s2_y;
  logic [PIX_NUM-1:0][2:0][SW-1:0] w_s3_p;
  logic [PIX_NUM-1:0][2:0][SW-1:0] r_s3_p;
  logic [PIX_NUM-1:0][SW-1:0]      w_s3_q;
  logic [PIX_NUM-1:0][SW-1:0]      r_s3_q;
  logic [PIX_NUM-1:0][PIX_W-1:0]   w_s4_pix;
  logic [PIX_NUM-1:0][PIX_W-1:0]   r_out;

  // The whole pipeline advances together whenever the output register can move.
  assign w_en     = !r_vld[3] || O_axis.tready;
  assign w_acc    = I_axis.tvalid && w_en;
  assign w_sof    = w_acc && I_axis.tuser;
  assign w_adj    = w_sof ? I_adj_val : r_adj;
  assign w_bypass = w_sof ? I_bypass : r_bypass;
  assign w_coef   = 10'(r_s2_adj) + 10'sd256;

  assign I_axis.tready = w_en;
  assign O_axis.tvalid = r_vld[3];
  assign O_axis.tuser  = r_user[3];
  assign O_axis.tlast  = r_last[3];
  assign O_axis.tdata  = r_out;
  assign O_frame_cnt   = r_frame_cnt;

  // Luma weight products; weights sum to 1024 so the sum never exceeds COMP_W+10 bits.
  always_comb begin
    for (int k = 0; k < PIX_NUM; k++) begin
      w_s1_prod[k][2] = PW'(I_axis.tdata[k*PIX_W + 2*COMP_W +: COMP_W]) * PW'(306);
      w_s1_prod[k][1] = PW'(I_axis.tdata[k*PIX_W + COMP_W +: COMP_W]) * PW'(601);
      w_s1_prod[k][0] = PW'(I_axis.tdata[k*PIX_W +: COMP_W]) * PW'(117);
    end
  end

  always_comb begin
    for (int k = 0; k < PIX_NUM; k++) begin
      w_s2_y[k] = COMP_W'((r_s1_prod[k][0] + r_s1_prod[k][1] + r_s1_prod[k][2]) >> 10);
    end
  end

  // (256+s) is in 0..511, so P stays positive; Q carries the sign of s.
  always_comb begin
    for (int k = 0; k < PIX_NUM; k++) begin
      for (int c = 0; c < 3; c++) begin
        w_s3_p[k][c] = SW'(w_coef) * $signed(SW'(r_s2_pix[k][c*COMP_W +: COMP_W]));
      end
      w_s3_q[k] = SW'(r_s2_adj) * $signed(SW'(r_s2_y[k]));
    end
  end

  always_comb begin
    logic signed [EW-1:0] w_d;
    logic signed [EW-1:0] w_r;
    w_d      = '0;
    w_r      = '0;
    w_s4_pix = '0;
    for (int k = 0; k < PIX_NUM; k++) begin
      for (int c = 0; c < 3; c++) begin
        w_d = EW'($signed(r_s3_p[k][c])) - EW'($signed(r_s3_q[k])) + EW'(128);
        w_r = w_d >>> 8;
        if (w_r < 0) begin
          w_s4_pix[k][c*COMP_W +: COMP_W] = '0;
        end else if (w_r > C_MAXV) begin
          w_s4_pix[k][c*COMP_W +: COMP_W] = C_MAX;
        end else begin
          w_s4_pix[k][c*COMP_W +: COMP_W] = w_r[COMP_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_adj       <= ADJ_DEFAULT;
      r_bypass    <= 1'b0;
      r_frame_cnt <= '0;
    end else if (w_sof) begin
      r_adj       <= I_adj_val;
      r_bypass    <= I_bypass;
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vld     <= '0;
      r_user    <= '0;
      r_last    <= '0;
      r_byp     <= '0;
      r_s1_adj  <= '0;
      r_s2_adj  <= '0;
      r_s1_pix  <= '0;
      r_s2_pix  <= '0;
      r_s3_pix  <= '0;
      r_s1_prod <= '0;
      r_s2_y    <= '0;
      r_s3_p    <= '0;
      r_s3_q    <= '0;
      r_out     <= '0;
    end else if (w_en) begin
      r_vld     <= {r_vld[2:0], I_axis.tvalid};
      r_user    <= {r_user[2:0], I_axis.tvalid && I_axis.tuser};
      r_last    <= {r_last[2:0], I_axis.tvalid && I_axis.tlast};
      r_byp     <= {r_byp[1:0], w_bypass};
      r_s1_adj  <= w_adj;
      r_s2_adj  <= r_s1_adj;
      r_s1_pix  <= I_axis.tdata;
      r_s2_pix  <= r_s1_pix;
      r_s3_pix  <= r_s2_pix;
      r_s1_prod <= w_s1_prod;
      r_s2_y    <= w_s2_y;
      r_s3_p    <= w_s3_p;
      r_s3_q    <= w_s3_q;
      r_out     <= r_byp[2] ? r_s3_pix : w_s4_pix;
    end
  end
endmodule

// File: tb/tb_saturation_adj_pp.sv
// Scoreboard bench for saturation_adj_pp: directed fixed-point cases, frame-latched settings,
// random backpressure, mid-frame reset and frame counter wrap.
`timescale 1ns/1ps
module tb_saturation_adj_pp;
  localparam int PIX_NUM = 4;
  localparam int COMP_W  = 8;
  localparam int DW      = PIX_NUM * 3 * COMP_W;
  localparam int CMAX    = (1 << COMP_W) - 1;
  localparam int TB_ADJ_DEFAULT = 64;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [8:0] adj_val = '0;
  logic              bypass  = 1'b0;
  logic [15:0]       frame_cnt;

  saturation_adj_pp_if #(.DATA_W(DW)) in_if();
  saturation_adj_pp_if #(.DATA_W(DW)) out_if();

  saturation_adj_pp #(
    .PIX_NUM(PIX_NUM), .COMP_W(COMP_W), .ADJ_DEFAULT(9'(TB_ADJ_DEFAULT))
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_axis(in_if), .O_axis(out_if),
    .I_adj_val(adj_val), .I_bypass(bypass), .O_frame_cnt(frame_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DW+1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int last_acc_cyc = 0;
  int last_pop_cyc = 0;
  int rdy_mode = 0;
  int m_adj;
  bit m_byp;
  logic [15:0] m_fc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int fdiv256(input int n);
    if (n >= 0) return n / 256;
    return -((-n + 255) / 256);
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input int s, input bit byp);
    logic [DW-1:0] o;
    int x[3];
    int y;
    int v;
    if (byp) return d;
    o = '0;
    for (int k = 0; k < PIX_NUM; k++) begin
      for (int c = 0; c < 3; c++) x[c] = int'(d[k*3*COMP_W + c*COMP_W +: COMP_W]);
      y = (306 * x[2] + 601 * x[1] + 117 * x[0]) / 1024;
      for (int c = 0; c < 3; c++) begin
        v = x[c] + fdiv256(s * (x[c] - y) + 128);
        if (v < 0) v = 0;
        if (v > CMAX) v = CMAX;
        o[k*3*COMP_W + c*COMP_W +: COMP_W] = COMP_W'(v);
      end
    end
    return o;
  endfunction

  function automatic logic [DW-1:0] pix(input int r, input int g, input int b);
    logic [DW-1:0] o;
    for (int k = 0; k < PIX_NUM; k++) o[k*3*COMP_W +: 3*COMP_W] = {COMP_W'(r), COMP_W'(g), COMP_W'(b)};
    return o;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i += 32) d[i +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_adj = TB_ADJ_DEFAULT;
    m_byp = 1'b0;
    m_fc  = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [DW-1:0] d, input bit u, input bit l, input int a, input bit b,
                            input bit use_exp, input logic [DW-1:0] exp_d);
    int w = 0;
    logic [DW-1:0] e;
    @(negedge clk);
    in_if.tdata  = d;
    in_if.tvalid = 1'b1;
    in_if.tuser  = u;
    in_if.tlast  = l;
    adj_val      = 9'(a);
    bypass       = b;
    #2;
    while (!in_if.tready && w < 1000) begin
      @(negedge clk);
      #2;
      w++;
    end
    if (!in_if.tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: tready stayed %0b, required 1", in_if.tready);
    end else begin
      last_acc_cyc = cyc;
      if (u) begin
        m_adj = a;
        m_byp = b;
        m_fc  = m_fc + 16'd1;
      end
      e = use_exp ? exp_d : model_beat(d, m_adj, m_byp);
      exp_q.push_back({u, l, e});
    end
    @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_if.tvalid = 1'b0;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  function automatic int rand_s();
    int s;
    s = int'($urandom_range(0, 511)) - 256;
    return s;
  endfunction

  // ---------------- downstream ready ----------------
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_if.tready = 1'b1;
        1: out_if.tready = 1'($urandom_range(0, 1));
        default: out_if.tready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [DW+1:0] got;
    logic [DW+1:0] held;
    logic [DW+1:0] e;
    bit stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        got = {out_if.tuser, out_if.tlast, out_if.tdata};
        if (stall) check("stall_hold", {out_if.tvalid, got}, {1'b1, held});
        if (out_if.tvalid && !out_if.tready) begin
          check("stall_in_ready", in_if.tready, 0);
          stall = 1'b1;
          held  = got;
        end else begin
          stall = 1'b0;
        end
        if (out_if.tvalid && out_if.tready) begin
          last_pop_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h with empty expected queue", got);
          end else begin
            e = exp_q.pop_front();
            check("beat", got, e);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached with %0d beats outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] d;
    int s;
    in_if.tdata  = '0;
    in_if.tvalid = 1'b0;
    in_if.tuser  = 1'b0;
    in_if.tlast  = 1'b0;
    model_reset();

    #12;
    check("reset_outputs", {out_if.tvalid, out_if.tuser, out_if.tlast, frame_cnt, out_if.tdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // identity and first-beat latency
    drive_beat(pix(200, 100, 50), 1, 0, 0, 0, 1, pix(200, 100, 50));
    wait_drain();
    check("latency", last_pop_cyc - last_acc_cyc, 4);
    drive_beat(pix(200, 100, 50), 0, 0, 128, 0, 1, pix(200, 100, 50));
    drive_beat(pix(200, 100, 50), 0, 1, -77, 0, 1, pix(200, 100, 50));
    check("frame_cnt_1", frame_cnt, 16'd1);

    // boost, latched at the SOF beat; later adjust changes ignored
    drive_beat(pix(200, 100, 50), 1, 0, 128, 0, 1, pix(238, 88, 13));
    drive_beat(pix(200, 100, 50), 0, 1, -256, 0, 1, pix(238, 88, 13));
    check("frame_cnt_2", frame_cnt, 16'd2);

    // desaturate to gray, then both clamps
    drive_beat(pix(200, 100, 50), 1, 1, -256, 0, 1, pix(124, 124, 124));
    drive_beat(pix(255, 0, 0), 1, 1, 255, 0, 1, pix(255, 0, 0));

    // bypass with the strongest adjust latched alongside it
    drive_beat(pix(200, 100, 50), 1, 0, 255, 1, 1, pix(200, 100, 50));
    d = rand_data();
    drive_beat(d, 0, 1, 0, 0, 1, d);
    wait_drain();

    // back-to-back 3-beat frames, each with its own setting
    for (int f = 0; f < 6; f++) begin
      s = rand_s();
      for (int b = 0; b < 3; b++) begin
        drive_beat(rand_data(), b == 0, b == 2, (b == 0) ? s : rand_s(), 1'($urandom_range(0, 4) == 0 && b == 0), 0, '0);
      end
      check("frame_cnt_step", frame_cnt, m_fc);
    end
    wait_drain();

    // random valid and ready
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      drive_beat(rand_data(), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, rand_s(),
                 $urandom_range(0, 3) == 0, 0, '0);
    end
    wait_drain();

    // reset in the middle of a stalled frame
    rdy_mode = 2;
    drive_beat(rand_data(), 1, 0, 100, 0, 0, '0);
    drive_beat(rand_data(), 0, 0, 100, 0, 0, '0);
    drive_beat(rand_data(), 0, 1, 100, 0, 0, '0);
    idle(3);
    check("pre_reset_valid", out_if.tvalid, 1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {out_if.tvalid, out_if.tuser, out_if.tlast, frame_cnt, out_if.tdata}, '0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(2);
    check("frame_cnt_after_reset", frame_cnt, 16'd0);
    drive_beat(pix(200, 100, 50), 0, 0, -256, 1, 0, '0);
    drive_beat(rand_data(), 0, 1, 0, 0, 0, '0);
    wait_drain();

    // frame counter wrap
    for (int i = 0; i < 65535; i++) begin
      drive_beat(rand_data(), 1, 1, rand_s(), $urandom_range(0, 7) == 0, 0, '0);
    end
    check("frame_cnt_ffff", frame_cnt, 16'hFFFF);
    drive_beat(rand_data(), 1, 1, rand_s(), 0, 0, '0);
    check("frame_cnt_wrap", frame_cnt, 16'h0000);
    wait_drain();
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
